// File: rtl/serie_paralelo_pkg.sv
// Shared constants for the serial-to-parallel byte receiver: comma byte,
// lock threshold and FSM state encodings.
package serie_paralelo_pkg;

    localparam logic [7:0] BC            = 8'hBC;
    localparam logic [2:0] SYNC_BC_COUNT = 3'd4;

    localparam logic [1:0] UNSYNC  = 2'd0;
    localparam logic [1:0] SYNCING = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;

    function automatic logic is_comma(input logic [7:0] byte_v);
        return (byte_v == BC);
    endfunction

endpackage

// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: aligns to the BC comma, locks after four
// aligned commas, then delivers each non-comma byte on its boundary edge.
module serie_paralelo
    import serie_paralelo_pkg::*;
(
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    logic [7:0] sr_q, sr_d;
    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       strobe_q, strobe_d;
    logic [7:0] next_byte_s;
    logic       boundary_s;

    // Next-state logic: shift register, alignment counters, FSM and output staging
    always_comb begin
        next_byte_s = {sr_q[6:0], data_in};
        boundary_s  = (bit_cnt_q == 3'd7);
        sr_d        = next_byte_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bc_cnt_d    = bc_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;

        case (state_q)
            UNSYNC: begin
                valid_d = 1'b0;
                // Search at every bit position until a comma shows up
                if (is_comma(next_byte_s)) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 3'd1;
                    state_d   = SYNCING;
                end else begin
                    bc_cnt_d  = 3'd0;
                end
            end
            SYNCING: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                valid_d   = 1'b0;
                if (boundary_s) begin
                    strobe_d = 1'b1;
                    if (is_comma(next_byte_s)) begin
                        if ((bc_cnt_q + 3'd1) >= SYNC_BC_COUNT) begin
                            bc_cnt_d = SYNC_BC_COUNT;
                            state_d  = ACTIVE;
                        end else begin
                            bc_cnt_d = bc_cnt_q + 3'd1;
                        end
                    end else begin
                        bc_cnt_d = 3'd0;
                        state_d  = UNSYNC;
                    end
                end else begin
                    strobe_d = 1'b0;
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary_s) begin
                    strobe_d = 1'b1;
                    // Commas in the locked stream are idle fillers, not data
                    if (is_comma(next_byte_s)) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = next_byte_s;
                        valid_d = 1'b1;
                    end
                end else begin
                    strobe_d = 1'b0;
                end
            end
            default: begin
                state_d  = UNSYNC;
                bc_cnt_d = 3'd0;
                valid_d  = 1'b0;
            end
        endcase

        active_d = (state_d == ACTIVE) ? 1'b1 : 1'b0;
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            sr_q      <= 8'h00;
            state_q   <= UNSYNC;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;

endmodule

// File: tb/tb_serie_paralelo.sv
// Self-checking bench for serie_paralelo: the bench serializes bytes MSB first
// and compares every edge against a bit-history reference model.
module tb_serie_paralelo;

    logic       clk_8f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    int checks;
    int errors;

    // Reference model state, kept as plain integers and a bit window
    logic [7:0] m_win;
    int         m_mode;   // 0 searching, 1 counting commas, 2 locked
    int         m_since;  // edges since the aligning comma
    int         m_commas;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;
    logic       m_strobe;

    serie_paralelo dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active      (active),
        .byte_strobe (byte_strobe)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic model_reset();
        m_win    = 8'h00;
        m_mode   = 0;
        m_since  = 0;
        m_commas = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
        m_strobe = 1'b0;
    endtask

    task automatic model_step(input logic b);
        m_win    = {m_win[6:0], b};
        m_strobe = 1'b0;
        if (m_mode == 0) begin
            if (m_win == 8'hBC) begin
                m_mode   = 1;
                m_since  = 0;
                m_commas = 1;
            end
        end else begin
            m_since = m_since + 1;
            if ((m_since % 8) == 0) begin
                m_strobe = 1'b1;
                if (m_mode == 1) begin
                    if (m_win == 8'hBC) begin
                        m_commas = m_commas + 1;
                        if (m_commas == 4) m_mode = 2;
                    end else begin
                        m_mode   = 0;
                        m_commas = 0;
                    end
                end else begin
                    if (m_win != 8'hBC) begin
                        m_data  = m_win;
                        m_valid = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                    end
                end
            end
        end
        m_active = (m_mode == 2);
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        model_step(b);
        #1;
        checks++;
        if ({data_out, valid_out, active, byte_strobe} !==
            {m_data, m_valid, m_active, m_strobe}) begin
            errors++;
            $display("FAIL edge_compare t=%0t got data=%h v=%b a=%b s=%b want data=%h v=%b a=%b s=%b",
                     $time, data_out, valid_out, active, byte_strobe,
                     m_data, m_valid, m_active, m_strobe);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_outs(input string name, input logic [7:0] d, input logic v,
                              input logic a);
        checks++;
        if ({data_out, valid_out, active} !== {d, v, a}) begin
            errors++;
            $display("FAIL %s got data=%h v=%b a=%b want data=%h v=%b a=%b",
                     name, data_out, valid_out, active, d, v, a);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_8f);
        reset   = 1'b0;
        data_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_8f);
            checks++;
            if ({data_out, valid_out, active, byte_strobe} !== 11'h000) begin
                errors++;
                $display("FAIL reset_hold got data=%h v=%b a=%b s=%b want all zero",
                         data_out, valid_out, active, byte_strobe);
            end
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic lock4();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_lock();
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_outs("pre_lock", 8'h00, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("lock_after_4bc", 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_data();
        send_byte(8'hFF);
        check_outs("data_ff", 8'hFF, 1'b1, 1'b1);
        send_byte(8'hEE);
        check_outs("data_ee", 8'hEE, 1'b1, 1'b1);
    endtask

    task automatic test_comma_in_active();
        send_byte(8'hBC);
        check_outs("comma_hold", 8'hEE, 1'b0, 1'b1);
        checks++;
        if (byte_strobe !== 1'b1) begin
            errors++;
            $display("FAIL comma_strobe got %b want 1", byte_strobe);
        end
    endtask

    task automatic test_lost_sync();
        apply_reset();
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_byte(8'h11);
        check_outs("unsync_after_11", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b0);
            checks++;
            if (byte_strobe !== 1'b0) begin
                errors++;
                $display("FAIL unsync_strobe got %b want 0", byte_strobe);
            end
        end
        lock4();
        check_outs("relock", 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_byte();
        send_byte(8'h5A);
        check_outs("pre_reset_data", 8'h5A, 1'b1, 1'b1);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        reset = 1'b0;
        #1;
        check_outs("async_reset", 8'h00, 1'b0, 1'b0);
        model_reset();
        @(negedge clk_8f);
        @(negedge clk_8f);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check_outs("post_reset_3bc", 8'h00, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("post_reset_lock", 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes_q [4];
        logic       vld_q   [4];
        bytes_q = '{8'h11, 8'hFF, 8'hFF, 8'hEE};
        vld_q   = '{1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        lock4();
        for (int i = 0; i < 4; i++) begin
            send_byte(vld_q[i] ? bytes_q[i] : 8'hBC);
            check_outs("loopback", vld_q[i] ? bytes_q[i] : 8'h00, vld_q[i], 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0] last_data;
        logic [7:0] b;
        apply_reset();
        lock4();
        last_data = 8'h00;
        for (int i = 0; i < 60; i++) begin
            b = ($urandom_range(0, 4) == 0) ? 8'hBC : 8'($urandom);
            send_byte(b);
            if (b != 8'hBC) last_data = b;
            check_outs("random_byte", last_data, (b != 8'hBC), 1'b1);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        data_in = 1'b0;
        model_reset();
        test_reset();
        test_lock();
        test_data();
        test_comma_in_active();
        test_lost_sync();
        test_reset_mid_byte();
        test_loopback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serie_paralelo.md
SERIE_PARALELO -- requirements
Module: serie_paralelo

Interface
REQ-001 clk_8f  input  1  bit-rate clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 = block held in reset.
REQ-003 data_in  input  1  serial line from the paralelo_serie stage, MSB of each byte first.
REQ-004 data_out  output  8  last recovered data byte.
REQ-005 valid_out  output  1  1 = data_out holds a data byte received in the current byte slot.
REQ-006 active  output  1  1 = byte alignment locked (state ACTIVE).
REQ-007 byte_strobe  output  1  one-cycle pulse on every byte-boundary edge while aligned (SYNCING or ACTIVE).

Function
REQ-008 Shift register: sr[7:0] SHALL load {sr[6:0], data_in} on every clk_8f edge; "next byte" below denotes {sr[6:0], data_in}.
REQ-009 The state machine SHALL have exactly three states: UNSYNC, SYNCING and ACTIVE.
REQ-010 In UNSYNC, the block SHALL compare next byte with 8'hBC on every edge (any bit alignment).
REQ-011 On that match, the block SHALL set bit_cnt to 0 and bc_cnt to 1, and move to SYNCING.
REQ-012 In SYNCING and ACTIVE, bit_cnt (3 bits) SHALL increment each edge and wrap 7->0; the edge on which bit_cnt==7 is the byte-boundary edge.
REQ-013 SYNCING, boundary edge, next byte==BC: bc_cnt SHALL increment; when it reaches 4, the state SHALL become ACTIVE and active SHALL go to 1 on that same edge.
REQ-014 SYNCING, boundary edge, next byte!=BC: the state SHALL return to UNSYNC and bc_cnt SHALL clear; the search restarts on the following edge.
REQ-015 ACTIVE, boundary edge, next byte!=BC: data_out SHALL load next byte and valid_out SHALL go to 1.
REQ-016 ACTIVE, boundary edge, next byte==BC: valid_out SHALL go to 0 and data_out SHALL hold its previous value.
REQ-017 valid_out and data_out SHALL change only on boundary edges; between boundaries they hold.
REQ-018 ACTIVE SHALL be left only by reset; no loss-of-lock detection.
REQ-019 Latency: a byte whose last bit is sampled at edge k SHALL appear on data_out/valid_out immediately after edge k (zero extra cycles).
REQ-020 byte_strobe SHALL be 1 for the single cycle following each boundary edge in SYNCING/ACTIVE; 0 in UNSYNC.
REQ-021 bc_cnt SHALL saturate at 4 and SHALL NOT count in ACTIVE.
REQ-022 valid_out SHALL be 0 in UNSYNC and SYNCING.

Reset
REQ-023 While reset=0, the block SHALL hold state=UNSYNC, with sr, bit_cnt, bc_cnt, data_out=8'h00, valid_out=0, active=0 and byte_strobe=0, asynchronously.
REQ-024 Reset asserted mid-byte in ACTIVE SHALL clear all outputs immediately; after release, full re-alignment (4 BC) SHALL be required.

Structure
REQ-025 Shared include SHALL define the comma constant BC=8'hBC, SYNC_BC_COUNT=4, and the state encodings (UNSYNC=2'd0, SYNCING=2'd1, ACTIVE=2'd2).
REQ-026 Implementation SHALL be a single module; no sub-module is required (shift register, counters and FSM are inline).
REQ-027 Testbench SHALL pair paralelo_serie -> serie_paralelo plus a probador-style generator and dump to S_P.vcd.

Verification
REQ-028 Reset low 3 cycles, then serial stream of 4 BC bytes preceded by 3 junk bits -> active=1 right after the boundary edge ending the 4th BC; valid_out=0.
REQ-029 After lock, send bytes FF, EE -> data_out=FF, valid_out=1 after 8 edges; then data_out=EE, valid_out=1.
REQ-030 In ACTIVE, send BC after EE -> valid_out=0, data_out stays EE, byte_strobe still pulses.
REQ-031 Send 3 BC then 11 -> state returns to UNSYNC, active stays 0; a following 4 BC -> lock.
REQ-032 Assert reset at bit 4 of a data byte in ACTIVE -> data_out=00, valid_out=0, active=0 with no clock edge; lock again only after 4 new BC.
REQ-033 Loopback with paralelo_serie driven with 11(valid 0), FF, FF, EE (valid 1) -> after lock, serie_paralelo outputs FF, FF, EE with valid_out=1 and BC slots with valid_out=0.
